// File: rtl/gwe_gen.sv
// gwe_gen: run/halt/single-step global write enable for the divided slow clock domain.
// Optional step_btn debounce filter when GWE_DEBOUNCE_EN is defined.
module gwe_gen #(
  parameter int DIV_LOG2  = 3,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run_en,
  input  logic                halt,
  input  logic                step_btn,
  output logic [DIV_LOG2-1:0] phase,
  output logic                gwe,
  output logic [1:0]          mode,
  output logic [CNT_W-1:0]    gwe_count
);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HALT = 2'b01,
    MODE_STEP = 2'b10
  } mode_t;

  mode_t mode_q;
  mode_t mode_nxt;
  logic  boundary;
  logic  sync1;
  logic  sync2;
  logic  btn_lvl;
  logic  lvl_q;
  logic  step_evt;
  logic  pend;

  assign mode     = mode_q;
  assign boundary = (phase == {DIV_LOG2{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      phase <= phase + DIV_LOG2'(1);
      sync1 <= step_btn;
      sync2 <= sync1;
      lvl_q <= btn_lvl;
    end
  end

`ifdef GWE_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  logic [DBW-1:0] db_cnt;
  logic           filt;

  // The filtered level flips only after DB_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync2 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      filt   <= sync2;
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  end

  assign btn_lvl = filt;
`else
  assign btn_lvl = sync2;
`endif

  assign step_evt = btn_lvl & ~lvl_q;

  // A press landing in the boundary cycle itself is honoured for that boundary.
  always_comb begin
    mode_nxt = MODE_HALT;
    if (halt) begin
      mode_nxt = MODE_HALT;
    end else if (run_en) begin
      mode_nxt = MODE_RUN;
    end else if (pend || step_evt) begin
      mode_nxt = MODE_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_HALT;
      gwe       <= 1'b0;
      gwe_count <= '0;
      pend      <= 1'b0;
    end else if (boundary) begin
      mode_q <= mode_nxt;
      gwe    <= (mode_nxt != MODE_HALT);
      pend   <= 1'b0;
      if (mode_nxt != MODE_HALT) begin
        gwe_count <= gwe_count + CNT_W'(1);
      end
    end else if (step_evt) begin
      pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gwe_gen.sv
// Scoreboard bench for gwe_gen: directed phases push expected state tagged with a cycle,
// a negedge monitor pops and compares. Define GWE_DEBOUNCE_EN to exercise the filter build.
module tb_gwe_gen;

  localparam logic [1:0] M_RUN  = 2'b00;
  localparam logic [1:0] M_HALT = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

`ifdef GWE_DEBOUNCE_EN
  localparam int WIN   = 24;
  localparam int PRESS = 20;
`else
  localparam int WIN   = 8;
  localparam int PRESS = 6;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        run_en;
  logic        halt;
  logic        step_btn;
  logic [2:0]  phase;
  logic        gwe;
  logic [1:0]  mode;
  logic [31:0] gwe_count;

  gwe_gen #(.DIV_LOG2(3), .DB_CYCLES(16), .CNT_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .run_en   (run_en),
    .halt     (halt),
    .step_btn (step_btn),
    .phase    (phase),
    .gwe      (gwe),
    .mode     (mode),
    .gwe_count(gwe_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [2:0]  ph;
    logic        g;
    logic [1:0]  m;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cnt_base;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input int ph, input logic g,
                           input logic [1:0] m, input int cnt);
    exp_t x;
    x.cyc  = cyc;
    x.name = nm;
    x.ph   = 3'(ph);
    x.g    = g;
    x.m    = m;
    x.cnt  = 32'(cnt);
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if (phase !== e.ph || gwe !== e.g || mode !== e.m || gwe_count !== e.cnt) begin
        errors++;
        $display("FAIL %s cyc=%0d got phase=%0d gwe=%0b mode=%0d cnt=%0d want phase=%0d gwe=%0b mode=%0d cnt=%0d",
                 e.name, cyc, phase, gwe, mode, gwe_count, e.ph, e.g, e.m, e.cnt);
      end
    end
  end

  initial begin
    rst = 1'b1; run_en = 1'b0; halt = 1'b0; step_btn = 1'b0;
    tick(2);
    rst = 1'b0;

    // Idle after reset: phase free-runs, nothing enabled.
    for (int k = 0; k < 64; k++) begin
      expect_st("idle", k % 8, 1'b0, M_HALT, 0);
      tick(1);
    end

    // run_en raised mid-period takes effect only at the next boundary.
    tick(2);
    run_en = 1'b1;
    for (int k = 2; k < 8; k++) begin
      expect_st("run_wait", k, 1'b0, M_HALT, 0);
      tick(1);
    end
    for (int k = 0; k < 24; k++) begin
      expect_st("run", k % 8, 1'b1, M_RUN, 1 + k / 8);
      tick(1);
    end

    // Halt at phase 5 waits for the boundary, then freezes the count.
    for (int k = 0; k < 5; k++) begin
      expect_st("run_pre_halt", k, 1'b1, M_RUN, 4);
      tick(1);
    end
    halt = 1'b1;
    for (int k = 5; k < 8; k++) begin
      expect_st("halt_wait", k, 1'b1, M_RUN, 4);
      tick(1);
    end
    for (int k = 0; k < 16; k++) begin
      expect_st("halted", k % 8, 1'b0, M_HALT, 4);
      tick(1);
    end
    halt = 1'b0;
    run_en = 1'b0;

    // Clean 20-cycle press: exactly one STEP window.
    for (int k = 0; k < 40; k++) begin
      step_btn = (k < 20);
      expect_st("step_clean", k % 8, (k >= WIN && k < WIN + 8),
                (k >= WIN && k < WIN + 8) ? M_STEP : M_HALT, (k >= WIN) ? 5 : 4);
      tick(1);
    end
    step_btn = 1'b0;
    cnt_base = 5;

`ifdef GWE_DEBOUNCE_EN
    // Bouncing button (3-cycle toggles) then a solid 40-cycle hold: one STEP window.
    for (int k = 0; k < 80; k++) begin
      step_btn = (k < 30) ? ((k / 3) % 2 == 0) : (k < 70);
      expect_st("step_bounce", k % 8, (k >= 56 && k < 64),
                (k >= 56 && k < 64) ? M_STEP : M_HALT, (k >= 56) ? 6 : 5);
      tick(1);
    end
    step_btn = 1'b0;
    cnt_base = 6;
`endif

    for (int k = 0; k < 16; k++) begin
      expect_st("idle2", k % 8, 1'b0, M_HALT, cnt_base);
      tick(1);
    end

    // Reset at phase 4 inside a STEP window aborts the step.
    for (int k = 0; k < WIN + 4; k++) begin
      step_btn = (k < PRESS);
      expect_st("rst_step", k % 8, (k >= WIN), (k >= WIN) ? M_STEP : M_HALT,
                (k >= WIN) ? cnt_base + 1 : cnt_base);
      tick(1);
    end
    step_btn = 1'b0;
    expect_st("rst_phase4", 4, 1'b1, M_STEP, cnt_base + 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      expect_st("post_rst", k % 8, 1'b0, M_HALT, 0);
      tick(1);
    end

    tick(1);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
